// File: rtl/i2c_slave_responder_if.sv
// Bus-side and strobe-side signals of the I2C target, bundled so the
// responder and its driver/monitor share one declaration.
interface i2c_slave_responder_if;
    logic       i2c_clk_i;
    logic       i2c_data_i;
    logic       i2c_data_oe_o;
    logic [7:0] wr_data_o;
    logic       wr_valid_o;
    logic       wr_first_o;
    logic       rd_req_o;
    logic [7:0] rd_data_i;
    logic       busy_o;

    modport slave (
        input  i2c_clk_i, i2c_data_i, rd_data_i,
        output i2c_data_oe_o, wr_data_o, wr_valid_o, wr_first_o, rd_req_o, busy_o
    );

    modport master (
        output i2c_clk_i, i2c_data_i, rd_data_i,
        input  i2c_data_oe_o, wr_data_o, wr_valid_o, wr_first_o, rd_req_o, busy_o
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// I2C target front end: oversampled SCL/SDA, START/STOP detection, 7-bit
// address match, write-byte strobes and read-byte requests. Never stretches
// SCL; SDA is open-drain (oe=1 pulls low).
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h48,
    parameter int         FILTER_LEN  = 3,   // 1..15
    parameter int         HOLD_CYCLES = 8    // >= 1, below SCL low time
) (
    input logic                   wb_clk_i,
    input logic                   wb_rst_n_i,
    i2c_slave_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    // index 0 = SCL, index 1 = SDA
    logic [1:0]      pad;
    logic [1:0][1:0] sync_q;
    logic [1:0][3:0] fcnt_q;
    logic [1:0]      filt_q, filt_p_q;

    assign pad = {bus.i2c_data_i, bus.i2c_clk_i};

    // Two-flop synchronizer plus glitch filter per line; filters idle high.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            sync_q   <= '1;
            fcnt_q   <= '0;
            filt_q   <= '1;
            filt_p_q <= '1;
        end else begin
            filt_p_q <= filt_q;
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][0], pad[i]};
                if (sync_q[i][1] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
                    filt_q[i] <= sync_q[i][1];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
    assign scl      = filt_q[0];
    assign sda      = filt_q[1];
    assign scl_rise =  filt_q[0] & ~filt_p_q[0];
    assign scl_fall = ~filt_q[0] &  filt_p_q[0];
    assign sda_rise =  filt_q[1] & ~filt_p_q[1];
    assign sda_fall = ~filt_q[1] &  filt_p_q[1];
    assign start_c  = sda_fall & scl;
    assign stop_c   = sda_rise & scl;

    logic [7:0] hold_q;
    logic       hold_done;
    assign hold_done = (hold_q == 8'd1);

    // Data-hold timer: fires HOLD_CYCLES clocks after each filtered SCL fall.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i)             hold_q <= '0;
        else if (start_c || stop_c)  hold_q <= '0;
        else if (scl_fall)           hold_q <= 8'(HOLD_CYCLES);
        else if (hold_q != 8'd0)     hold_q <= hold_q - 8'd1;
    end

    state_t     state_q, state_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] sh_q, sh_d, wr_data_q, wr_data_d, byte_in;
    logic       rw_q, rw_d, first_q, first_d, oe_q, oe_d, busy_q, busy_d;
    logic       wr_valid_q, wr_valid_d, wr_first_q, wr_first_d, rd_req_q, rd_req_d;

    assign byte_in = {sh_q[6:0], sda};

    // FSM and datapath state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q    <= IDLE;
            bit_q      <= '0;
            sh_q       <= '0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            wr_first_q <= 1'b0;
            rd_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            rw_q       <= rw_d;
            first_q    <= first_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            wr_first_q <= wr_first_d;
            rd_req_q   <= rd_req_d;
        end
    end

    // Next-state logic; START/STOP override any bit-level edge.
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        rw_d       = rw_q;
        first_d    = first_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_data_d  = wr_data_q;
        wr_first_d = wr_first_q;
        wr_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        if (start_c) begin
            state_d = ADDR;
            bit_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (stop_c) begin
            state_d = IDLE;
            bit_d   = '0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise && bit_q != 4'd8) begin
                        sh_d  = byte_in;
                        bit_d = bit_q + 4'd1;
                        rw_d  = byte_in[0];
                        if (bit_q == 4'd7 && byte_in[7:1] != SLAVE_ADDR)
                            state_d = WAIT_STOP;
                    end else if (hold_done && bit_q == 4'd8) begin
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (rw_q) begin
                        if (scl_rise) begin
                            rd_req_d = 1'b1;
                        end else if (scl_fall) begin
                            sh_d    = bus.rd_data_i;
                            bit_d   = '0;
                            state_d = RD_BYTE;
                        end
                    end else if (hold_done) begin
                        oe_d    = 1'b0;
                        first_d = 1'b1;
                        bit_d   = '0;
                        state_d = WR_BYTE;
                    end
                end
                WR_BYTE: begin
                    if (scl_rise && bit_q != 4'd8) begin
                        sh_d  = byte_in;
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd7) begin
                            wr_data_d  = byte_in;
                            wr_valid_d = 1'b1;
                            wr_first_d = first_q;
                            first_d    = 1'b0;
                        end
                    end else if (hold_done && bit_q == 4'd8) begin
                        oe_d    = 1'b1;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (hold_done) begin
                        oe_d    = 1'b0;
                        bit_d   = '0;
                        state_d = WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    // ACK (or previous bit) stays on the bus until the hold point
                    if (hold_done) begin
                        if (bit_q == 4'd8) begin
                            oe_d    = 1'b0;
                            bit_d   = '0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d  = ~sh_q[7];
                            sh_d  = {sh_q[6:0], 1'b0};
                            bit_d = bit_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda) state_d  = WAIT_STOP;
                        else     rd_req_d = 1'b1;
                    end else if (scl_fall) begin
                        sh_d    = bus.rd_data_i;
                        bit_d   = '0;
                        state_d = RD_BYTE;
                    end
                end
                IDLE, WAIT_STOP: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Reset gates the pull-down directly so SDA frees in the reset cycle.
    assign bus.i2c_data_oe_o = oe_q & wb_rst_n_i;
    assign bus.wr_data_o     = wr_data_q;
    assign bus.wr_valid_o    = wr_valid_q;
    assign bus.wr_first_o    = wr_first_q;
    assign bus.rd_req_o      = rd_req_q;
    assign bus.busy_o        = busy_q;
endmodule
